// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked sequential ALU with iterative divide and optional iterative multiply
// SEQ_ALU_FAST_MUL_EN selects a single-cycle multiplier; undefined gives shift-add multiply.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_flags,
  output logic             out_err
);

  localparam int LG = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [LG-1:0]    LAST = LG'(WIDTH - 1);

  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_MUL = 5'b00010,
                         OP_DIV = 5'b00011, OP_MOD = 5'b00100, OP_CMP = 5'b00101,
                         OP_AND = 5'b00110, OP_OR  = 5'b00111, OP_NOT = 5'b01000,
                         OP_MOV = 5'b01001, OP_LSL = 5'b01010, OP_LSR = 5'b01011,
                         OP_ASR = 5'b01100, OP_NOP = 5'b01101, OP_LDA = 5'b01110,
                         OP_STA = 5'b01111, OP_SET = 5'b11000, OP_RST = 5'b11001;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_n;
  logic [LG-1:0]    cnt;
  logic [4:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r, rem, quo;
  logic [WIDTH-1:0] alu_res, rem_n, quo_n, acc_n, fin;
  logic [WIDTH:0]   rem_sh, diff;
  logic [LG-1:0]    shamt;
  logic             alu_err, multi, big, b_zero, ge, accept;

  assign shamt  = in_b[LG-1:0];
  assign big    = |(in_b >> LG);
  assign b_zero = (in_b == '0);
  assign accept = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    multi   = 1'b0;
    case (in_op)
      OP_ADD, OP_LDA, OP_STA: alu_res = in_a + in_b;
      OP_SUB: alu_res = in_a - in_b;
`ifdef SEQ_ALU_FAST_MUL_EN
      OP_MUL: alu_res = in_a * in_b;
`else
      OP_MUL: multi = 1'b1;
`endif
      OP_DIV: begin
        if (b_zero) begin
          alu_res = '1;
          alu_err = 1'b1;
        end else multi = 1'b1;
      end
      OP_MOD: begin
        if (b_zero) begin
          alu_res = in_a;
          alu_err = 1'b1;
        end else multi = 1'b1;
      end
      OP_CMP, OP_NOP: alu_res = '0;
      OP_AND: alu_res = in_a & in_b;
      OP_OR:  alu_res = in_a | in_b;
      OP_NOT: alu_res = ~in_b;
      OP_MOV: alu_res = in_b;
      OP_LSL: alu_res = big ? '0 : in_a << shamt;
      OP_LSR: alu_res = big ? '0 : in_a >> shamt;
      OP_ASR: alu_res = big ? {WIDTH{in_a[WIDTH-1]}} : $signed(in_a) >>> shamt;
      OP_SET: alu_res = big ? '0 : ONE << shamt;
      OP_RST: alu_res = big ? '1 : ~(ONE << shamt);
      default: alu_err = 1'b1;
    endcase
  end

  // Restoring divide step: the stored remainder is always below the divisor, so only the
  // shifted WIDTH+1-bit partial remainder needs the extra bit.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, b_r};
    ge     = ~diff[WIDTH];
    rem_n  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_n  = {quo[WIDTH-2:0], ge};
    acc_n  = rem + (quo[0] ? a_r : '0);
    if (op_r == OP_DIV)      fin = quo_n;
    else if (op_r == OP_MOD) fin = rem_n;
    else                     fin = acc_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = (state == IDLE) || (state == DONE && out_ready);
    out_valid = (state == DONE);
    case (state)
      IDLE: if (accept) state_n = multi ? BUSY : DONE;
      BUSY: if (cnt == LAST) state_n = DONE;
      DONE: begin
        if (accept)         state_n = multi ? BUSY : DONE;
        else if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Multiply reuses rem as accumulator and quo as the right-shifting multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      op_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      rem        <= '0;
      quo        <= '0;
      out_result <= '0;
      out_err    <= 1'b0;
      out_flags  <= 2'b00;
    end else if (accept) begin
      op_r <= in_op;
      a_r  <= in_a;
      b_r  <= in_b;
      cnt  <= '0;
      rem  <= '0;
      quo  <= (in_op == OP_MUL) ? in_b : in_a;
      if (!multi) begin
        out_result <= alu_res;
        out_err    <= alu_err;
      end
      if (in_op == OP_CMP) out_flags <= {in_a > in_b, in_a == in_b};
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      if (op_r == OP_MUL) begin
        rem <= acc_n;
        a_r <= a_r << 1;
        quo <= quo >> 1;
      end else begin
        rem <= rem_n;
        quo <= quo_n;
      end
      if (cnt == LAST) begin
        out_result <= fin;
        out_err    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked ALU for the pipelined core; it replaces the purely combinational ALU in the execute stage. It accepts one operation at a time over a valid/ready interface and returns a registered result and error bit. The compare flags are registered and persistent. Divide and modulo are multi-cycle; multiply is single-cycle or iterative depending on configuration.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 4 and a power of two.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- in_op  in  5  opcode.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result this cycle.
- out_result  out  WIDTH  registered result.
- out_flags  out  2  [1] = gt, [0] = eq; persistent compare flags.
- out_err  out  1  divide/modulo by zero, or illegal opcode.

## Operation
- Opcodes (unsigned arithmetic unless noted):
  - 00000 add; 01110 load-address add; 01111 store-address add.
  - 00001 sub.
  - 00010 mul, low WIDTH bits of the product.
  - 00011 div; 00100 mod.
  - 00101 cmp: result 0; flags = {a>b, a==b}; a<b gives 00.
  - 00110 and; 00111 or; 01000 not b; 01001 mov b.
  - 01010 lsl; 01011 lsr; 01100 asr, signed.
  - 01101 nop: result 0.
  - 11000 set: 1<<b; 11001 reset: ~(1<<b).
- Shift-amount rules for b ≥ WIDTH:
  - lsl, lsr, set: result 0.
  - asr: result is all copies of a[WIDTH-1].
  - reset: result all ones.
- Flags are written only by cmp. All other ops leave them unchanged. Reset clears them to 00.
- Divide by zero: div returns all ones, mod returns a, out_err = 1.
- Illegal opcode: result 0, out_err = 1, flags unchanged.
- FSM states:
  - IDLE → BUSY on accept of div/mod, or of mul when iterative.
  - IDLE → DONE on accept of any other op.
  - BUSY → DONE when the iteration counter reaches WIDTH-1.
  - DONE → IDLE on out_ready, unless a new op is accepted in the same cycle; in that case the FSM follows the IDLE accept rule.
- Handshake rules:
  - An op is accepted when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - out_valid = (state==DONE).
  - out_result, out_err and out_flags stay stable while out_valid && !out_ready.
- Operands are captured at accept, so input changes during BUSY are ignored.
- Divider: restoring, one quotient bit per cycle, MSB first, with a WIDTH+1-bit partial remainder.
- Division by zero is detected at accept. It goes straight to DONE and skips BUSY.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_result = 0, out_flags = 00, out_err = 0, state = IDLE, counter = 0.
- Single-cycle ops: accepted at edge N, out_valid high after edge N+1 (latency 1).
- div/mod: latency WIDTH+1 cycles from accept to out_valid.
- Iterative mul: latency WIDTH+1 cycles.
- Throughput: back-to-back single-cycle ops sustain one per cycle when out_ready is held high.
- Reset asserted mid-operation (BUSY or DONE) aborts the op immediately: the FSM returns to IDLE and all outputs take their reset values. No result is emitted.
- Simultaneous out_ready and a new accept in DONE: the old result retires and the new op starts on the same edge.

## Configuration
- SEQ_ALU_FAST_MUL_EN
  - Defined: mul is single-cycle (combinational multiplier, latency 1).
  - Undefined: mul is shift-add, one bit per cycle, latency WIDTH+1, sharing the BUSY state and counter with the divider.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold rst_n low with in_valid = 1 → in_ready = 1, out_valid = 0, out_result = 0, out_flags = 00.
- Back-to-back ops, out_ready = 1, WIDTH = 32:
  - add 5+7 → 12.
  - asr 0x80000000 by 4 → 0xF8000000.
  - lsl 1 by 40 → 0.
  - Results arrive on consecutive cycles.
- Div/mod, WIDTH = 32:
  - div 100/7 → 14 after 33 cycles; mod 100%7 → 2.
  - div 9/0 → 0xFFFFFFFF, out_err = 1, after 1 cycle.
- Compare and persistence:
  - cmp 9,3 → flags 10.
  - Following add → flags still 10.
  - cmp 4,4 → flags 01.
  - cmp 2,8 → flags 00.
- Backpressure: out_ready = 0 for 5 cycles after a mul 6*7 → result 42 held stable and in_ready = 0 throughout. Latency is 1 cycle with the macro defined, 33 cycles without.
- Reset mid-div: assert rst_n low at cycle 10 of a div → out_valid never rises for that op, and the next op completes normally.
